result_fifo_responder: RTL and testbench

- Responder end of the controller's 2-bit fifo_command interface.
- Captures one datapath result word per WRITE command into an internal buffer.
- On a READ command, streams the whole buffer out to an external reader over a valid/ready handshake, oldest word first.
- Sits between the adder-tree output of the convolution datapath and the external memory/host port.

---
 rtl/result_fifo_responder.sv | 177 +++++++++++++++++
 tb/tb_result_fifo_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/result_fifo_responder.sv
// Result FIFO responder: buffers one datapath word per WRITE and drains the whole buffer on READ.
// Optional per-entry even parity is enabled with `define RESULT_FIFO_PARITY_EN.
module result_fifo_responder #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            fifo_command,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  drain_done,
  output logic                  busy,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
`ifdef RESULT_FIFO_PARITY_EN
  output logic                  rd_parity_err,
  output logic                  parity_fault,
`endif
  output logic                  overflow,
  output logic                  cmd_err
);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b11;
  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_TWO  = (ADDR_WIDTH+1)'(2);

`ifdef RESULT_FIFO_PARITY_EN
  localparam int ENT_W = DATA_WIDTH + 1;
`else
  localparam int ENT_W = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d, rd_addr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  rd_valid_q, rd_last_q, drain_done_q, overflow_q, cmd_err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [ENT_W-1:0]      mem [DEPTH];
  logic [ENT_W-1:0]      wr_word, rd_word;
  logic                  wr_en, handshake;
`ifdef RESULT_FIFO_PARITY_EN
  logic                  rd_parity_err_q, parity_fault_q, rd_word_perr;
`endif

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != IDLE);
  assign handshake = rd_valid_q && rd_ready;
  assign rd_ptr_d  = rd_ptr_q + 1'b1;
  // IDLE loads the head word; STREAM prefetches the one after the word being accepted.
  assign rd_addr   = (state_q == IDLE) ? rd_ptr_q : rd_ptr_d;
  assign rd_word   = mem[rd_addr];
  assign wr_en     = !reset && (fifo_command == CMD_WRITE) && (state_q == IDLE) && !full;

`ifdef RESULT_FIFO_PARITY_EN
  assign wr_word      = {^wr_data, wr_data};
  assign rd_word_perr = ^rd_word;
`else
  assign wr_word      = wr_data;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
      drain_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
`ifdef RESULT_FIFO_PARITY_EN
      rd_parity_err_q <= 1'b0;
      parity_fault_q  <= 1'b0;
`endif
    end else if (fifo_command == CMD_CLEAR) begin
      // Abort any drain silently; rd_data keeps its last value.
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      drain_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
`ifdef RESULT_FIFO_PARITY_EN
      rd_parity_err_q <= 1'b0;
      parity_fault_q  <= 1'b0;
`endif
    end else begin
      drain_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fifo_command == CMD_WRITE) begin
            if (full) begin
              overflow_q <= 1'b1;
            end else begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              count_q  <= count_q + 1'b1;
            end
          end else if (fifo_command == CMD_READ) begin
            if (empty) begin
              state_q      <= DONE;
              drain_done_q <= 1'b1;
            end else begin
              state_q    <= STREAM;
              rd_valid_q <= 1'b1;
              rd_data_q  <= rd_word[DATA_WIDTH-1:0];
              rd_last_q  <= (count_q == CNT_ONE);
`ifdef RESULT_FIFO_PARITY_EN
              rd_parity_err_q <= rd_word_perr;
              if (rd_word_perr) parity_fault_q <= 1'b1;
`endif
            end
          end
        end
        STREAM: begin
          if (fifo_command == CMD_WRITE) cmd_err_q <= 1'b1;
          if (handshake) begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_q - 1'b1;
            if (rd_last_q) begin
              rd_valid_q   <= 1'b0;
              rd_last_q    <= 1'b0;
              state_q      <= DONE;
              drain_done_q <= 1'b1;
            end else begin
              rd_data_q <= rd_word[DATA_WIDTH-1:0];
              rd_last_q <= (count_q == CNT_TWO);
`ifdef RESULT_FIFO_PARITY_EN
              rd_parity_err_q <= rd_word_perr;
              if (rd_word_perr) parity_fault_q <= 1'b1;
`endif
            end
          end
        end
        DONE: begin
          if (fifo_command == CMD_WRITE) cmd_err_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_last    = rd_last_q;
  assign drain_done = drain_done_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign cmd_err    = cmd_err_q;
`ifdef RESULT_FIFO_PARITY_EN
  assign rd_parity_err = rd_parity_err_q;
  assign parity_fault  = parity_fault_q;
`endif

endmodule

// File: tb/tb_result_fifo_responder.sv
// Scoreboard bench for result_fifo_responder at DEPTH=4: stimulus pushes expected words, a negedge monitor pops them.
module tb_result_fifo_responder;
  localparam int DW = 20;
  localparam int AW = 2;
  localparam logic [1:0] NOP = 2'b00, WR = 2'b10, RD = 2'b01, CLR = 2'b11;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    fifo_command;
  logic [DW-1:0] wr_data;
  logic          rd_ready;
  logic          rd_valid, rd_last, drain_done, busy, full, empty, overflow, cmd_err;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;
  logic [DW:0] sb[$];  // {last, data}

  result_fifo_responder #(.DATA_WIDTH(DW), .DEPTH(4), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .fifo_command(fifo_command), .wr_data(wr_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .drain_done(drain_done), .busy(busy), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d, input bit expect_out, input bit last);
    if (expect_out) sb.push_back({last, d});
    fifo_command = WR; wr_data = d;
    tick();
    fifo_command = NOP;
  endtask

  // Issue READ and wait (bounded) for drain_done; toggle applies rd_ready pattern 1,0,0,1.
  task automatic drain(input bit toggle, input string name);
    rd_ready = 1'b1;
    fifo_command = RD;
    tick();
    fifo_command = NOP;
    for (int c = 0; c < 40; c++) begin
      if (drain_done) break;
      rd_ready = toggle ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      tick();
    end
    chk({name, "_drain_done"}, drain_done, 1);
    tick();
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_count_after"}, count, 0);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data;
  logic [1:0]    cmd_prev = 2'b00;
  logic [DW:0]   exp_w;
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && cmd_prev != CLR) begin
        chk("stall_valid", rd_valid, 1);
        chk("stall_data", rd_data, stall_data);
      end
      stall_q    = rd_valid && !rd_ready;
      stall_data = rd_data;
      cmd_prev   = fifo_command;
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h expected no word at %0t", rd_data, $time);
        end else begin
          exp_w = sb.pop_front();
          chk("rd_data", rd_data, exp_w[DW-1:0]);
          chk("rd_last", rd_last, exp_w[DW]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; fifo_command = NOP; wr_data = '0; rd_ready = 1'b0;
    tick(); tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_flags", {drain_done, overflow, cmd_err, rd_last}, 0);
    reset = 1'b0;

    // Basic 3-word drain at full throughput.
    write_word(20'h00011, 1, 0);
    write_word(20'h00022, 1, 0);
    write_word(20'h00033, 1, 1);
    chk("t1_count3", count, 3);
    rd_ready = 1'b1; fifo_command = RD;
    tick(); fifo_command = NOP;
    chk("t1_w0", {rd_valid, rd_last, rd_data}, {2'b10, 20'h00011});
    tick();
    chk("t1_w1", {rd_valid, rd_last, rd_data}, {2'b10, 20'h00022});
    tick();
    chk("t1_w2", {rd_valid, rd_last, rd_data}, {2'b11, 20'h00033});
    tick();
    chk("t1_done", {drain_done, rd_valid, busy}, 3'b101);
    tick();
    chk("t1_idle", {drain_done, busy, empty}, 3'b001);
    chk("t1_count0", count, 0);

    // Overflow: fifth write is dropped.
    write_word(20'h000A1, 1, 0);
    write_word(20'h000A2, 1, 0);
    write_word(20'h000A3, 1, 0);
    chk("t2_not_full3", full, 0);
    write_word(20'h000A4, 1, 1);
    chk("t2_full4", full, 1);
    chk("t2_ovf_before", overflow, 0);
    write_word(20'h000A5, 0, 0);
    chk("t2_ovf", overflow, 1);
    chk("t2_count4", count, 4);
    drain(0, "t2");

    // Stalled drain with rd_ready toggling.
    write_word(20'hB0001, 1, 0);
    write_word(20'hB0002, 1, 0);
    write_word(20'hB0003, 1, 0);
    write_word(20'hB0004, 1, 1);
    drain(1, "t3");

    // WRITE during STREAM is dropped and flagged.
    write_word(20'h000C1, 1, 0);
    write_word(20'h000C2, 1, 0);
    write_word(20'h000C3, 1, 1);
    rd_ready = 1'b0; fifo_command = RD;
    tick();
    chk("t4_cmd_err_before", cmd_err, 0);
    fifo_command = WR; wr_data = 20'hDEAD0;
    tick(); fifo_command = NOP;
    chk("t4_cmd_err", cmd_err, 1);
    chk("t4_count", count, 3);
    drain(0, "t4");

    // READ on empty buffer.
    fifo_command = RD;
    tick(); fifo_command = NOP;
    chk("t5_done", {drain_done, busy, rd_valid}, 3'b110);
    tick();
    chk("t5_idle", {drain_done, busy, rd_valid}, 3'b000);

    // CLEAR after two of four words.
    write_word(20'h000E1, 1, 0);
    write_word(20'h000E2, 1, 0);
    write_word(20'h000E3, 0, 0);
    write_word(20'h000E4, 0, 0);
    rd_ready = 1'b1; fifo_command = RD;
    tick(); fifo_command = NOP;
    tick(); tick();
    rd_ready = 1'b0; fifo_command = CLR;
    tick(); fifo_command = NOP;
    chk("t6_busy", busy, 0);
    chk("t6_valid", rd_valid, 0);
    chk("t6_count", count, 0);
    chk("t6_no_done", drain_done, 0);
    chk("t6_sticky_clr", {overflow, cmd_err}, 0);
    tick();
    chk("t6_no_done2", drain_done, 0);
    write_word(20'h000F1, 1, 0);
    write_word(20'h000F2, 1, 1);
    drain(0, "t6");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
